// File: rtl/reg_file_sb.sv
// Multi-port CPU register file: NUM_RD async read ports, two byte-strobed write ports
// and a per-register busy scoreboard. Define REG_FILE_SB_BYPASS_EN for write-to-read forwarding.
module reg_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rbusy,
  input  logic                         wen0,
  input  logic [ADDR_WIDTH-1:0]        waddr0,
  input  logic [DATA_WIDTH/8-1:0]      wstrb0,
  input  logic [DATA_WIDTH-1:0]        wdata0,
  input  logic                         wen1,
  input  logic [ADDR_WIDTH-1:0]        waddr1,
  input  logic [DATA_WIDTH/8-1:0]      wstrb1,
  input  logic [DATA_WIDTH-1:0]        wdata1,
  input  logic                         wclr1,
  input  logic                         mark_en,
  input  logic [ADDR_WIDTH-1:0]        mark_addr,
  output logic                         busy_any
);

  localparam int NREG = 2 ** ADDR_WIDTH;
  localparam int NB   = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs [NREG];
  logic [NREG-1:0]       busy;

  // Register 0 is only ever written by reset, so it reads as zero and never goes busy.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
      busy <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        for (int b = 0; b < NB; b++) begin
          if (wen1 && waddr1 == ADDR_WIDTH'(r) && wstrb1[b]) begin
            regs[r][8*b +: 8] <= wdata1[8*b +: 8];
          end else if (wen0 && waddr0 == ADDR_WIDTH'(r) && wstrb0[b]) begin
            regs[r][8*b +: 8] <= wdata0[8*b +: 8];
          end
        end
        // A newly issued producer supersedes the one retiring this cycle.
        if (mark_en && mark_addr == ADDR_WIDTH'(r)) begin
          busy[r] <= 1'b1;
        end else if (wen1 && wclr1 && waddr1 == ADDR_WIDTH'(r)) begin
          busy[r] <= 1'b0;
        end
      end
    end
  end

  assign busy_any = |busy;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    assign ra = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef REG_FILE_SB_BYPASS_EN
    logic [DATA_WIDTH-1:0] rd;
    always_comb begin
      rd = regs[ra];
      for (int b = 0; b < NB; b++) begin
        if (wen1 && waddr1 == ra && ra != '0 && wstrb1[b]) begin
          rd[8*b +: 8] = wdata1[8*b +: 8];
        end else if (wen0 && waddr0 == ra && ra != '0 && wstrb0[b]) begin
          rd[8*b +: 8] = wdata0[8*b +: 8];
        end
      end
    end
    assign rdata[k*DATA_WIDTH +: DATA_WIDTH] = rd;
    assign rbusy[k] = busy[ra] &&
                      !(wen1 && wclr1 && waddr1 == ra && !(mark_en && mark_addr == ra));
`else
    assign rdata[k*DATA_WIDTH +: DATA_WIDTH] = regs[ra];
    assign rbusy[k] = busy[ra];
`endif
  end

endmodule
